// File: rtl/branch_predict_unit.sv
// Branch unit with direct-mapped BTB: IF-stage next-PC prediction, EX-stage resolution,
// mispredict redirect/flush, sticky halt and a saturating mispredict counter.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  f_pc,
  output logic             f_pred_taken,
  output logic [PC_W-1:0]  f_pred_target,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_is_jump,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  input  logic             halt,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             halted,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;
  localparam int TAG_S = (TAG_W > 0) ? TAG_W : 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_valid [ENTRIES];
  logic             r_jmp   [ENTRIES];
  logic [1:0]       r_ctr   [ENTRIES];
  logic [TAG_S-1:0] r_tag   [ENTRIES];
  logic [PC_W-1:0]  r_tgt   [ENTRIES];
  logic [CNT_W-1:0] r_cnt;

  logic [IDX_W-1:0] w_f_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_S-1:0] w_f_tag;
  logic [TAG_S-1:0] w_ex_tag;
  logic             w_f_hit;
  logic             w_ex_hit;
  logic             w_run;
  logic             w_mispred;
  logic [31:0]      w_actual_pc;
  logic             w_unused;

  assign w_f_idx  = f_pc[IDX_W+1:2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];

  // With TAG_W=0 every stored tag is zero, so the compare is always true.
  generate
    if (TAG_W > 0) begin : g_tag
      assign w_f_tag  = f_pc[PC_W-1:IDX_W+2];
      assign w_ex_tag = ex_pc[PC_W-1:IDX_W+2];
    end else begin : g_notag
      assign w_f_tag  = '0;
      assign w_ex_tag = '0;
    end
  endgenerate

  assign w_unused = ^f_pc[1:0];

  assign w_run    = (r_state == ST_RUN);
  assign w_f_hit  = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  assign f_pred_taken  = w_f_hit && (r_jmp[w_f_idx] || r_ctr[w_f_idx][1]);
  assign f_pred_target = r_tgt[w_f_idx];

  assign w_actual_pc = ex_taken ? ex_target : ({{(32-PC_W){1'b0}}, ex_pc} + 32'd4);
  assign w_mispred   = ex_valid && ((ex_pred_taken != ex_taken) ||
                       (ex_taken && (ex_pred_target != ex_target[PC_W-1:0])));

  assign redirect       = w_mispred && w_run;
  assign redirect_pc    = redirect ? w_actual_pc : 32'd0;
  assign halted         = (r_state == ST_HALTED);
  assign mispredict_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b00;
      end
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      if (redirect && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);

      if (ex_valid && w_run) begin
        if (w_ex_hit) begin
          if (ex_is_jump) begin
            r_tgt[w_ex_idx] <= ex_target[PC_W-1:0];
            r_ctr[w_ex_idx] <= 2'b11;
          end else if (ex_taken) begin
            r_tgt[w_ex_idx] <= ex_target[PC_W-1:0];
            if (r_ctr[w_ex_idx] != 2'b11)
              r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
          end else if (r_ctr[w_ex_idx] != 2'b00) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          r_valid[w_ex_idx] <= 1'b1;
          r_tag[w_ex_idx]   <= w_ex_tag;
          r_tgt[w_ex_idx]   <= ex_target[PC_W-1:0];
          r_jmp[w_ex_idx]   <= ex_is_jump;
          r_ctr[w_ex_idx]   <= ex_is_jump ? 2'b11 : 2'b10;
        end
      end

      // A mispredict in the same cycle wins; the pipe re-issues the halt.
      if (w_run && halt && !redirect)
        r_state <= ST_HALTED;
    end
  end

endmodule
